// File: rtl/tb_dmem_responder.sv
// Data-memory responder: word RAM with fixed-latency, in-order tagged acks.
// Define TB_DMEM_STALL_EN to add LFSR-driven random accept stalls.
module tb_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_d_addr_w,
    input  logic [31:0] mem_d_data_wr_w,
    input  logic        mem_d_rd_w,
    input  logic [3:0]  mem_d_wr_w,
    input  logic        mem_d_cacheable_w,
    input  logic [10:0] mem_d_req_tag_w,
    input  logic        mem_d_invalidate_w,
    input  logic        mem_d_writeback_w,
    input  logic        mem_d_flush_w,
    input  logic        bd_wr_i,
    input  logic [31:0] bd_addr_i,
    input  logic [31:0] bd_data_i,
    output logic        mem_d_accept_w,
    output logic        mem_d_ack_w,
    output logic        mem_d_error_w,
    output logic [10:0] mem_d_resp_tag_w,
    output logic [31:0] mem_d_data_rd_w
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [3:0] CD_INIT = 4'(LATENCY - 1);

    logic [31:0]   r_mem  [DEPTH_WORDS];
    logic [10:0]   r_tag  [OUTSTANDING];
    logic [31:0]   r_data [OUTSTANDING];
    logic          r_err  [OUTSTANDING];
    logic [3:0]    r_cd   [OUTSTANDING];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ack;
    logic          r_ack_err;
    logic [10:0]   r_ack_tag;
    logic [31:0]   r_ack_data;

    logic          w_req_valid;
    logic          w_take;
    logic          w_pop;
    logic          w_stall;
    logic          w_idx_ok;
    logic          w_err;
    logic          w_core_wr;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_data;
    logic          w_bd_ok;
    logic [AW-1:0] w_bd_idx;
    logic          w_unused;

    assign w_unused = &{1'b0, mem_d_cacheable_w, mem_d_addr_w[1:0]};

    assign w_req_valid = mem_d_rd_w | (|mem_d_wr_w) | mem_d_flush_w
                       | mem_d_invalidate_w | mem_d_writeback_w;
    assign mem_d_accept_w = rst_n & (r_count < CW'(OUTSTANDING)) & ~w_stall;
    assign w_take = w_req_valid & mem_d_accept_w;
    assign w_pop  = (r_count != '0) && (r_cd[r_rd_ptr] == 4'd0);

    assign w_idx_ok  = {2'b00, mem_d_addr_w[31:2]} < DEPTH_WORDS;
    assign w_err     = ~w_idx_ok | (mem_d_rd_w & (|mem_d_wr_w));
    assign w_idx     = mem_d_addr_w[AW+1:2];
    assign w_core_wr = w_take & ~w_err & (|mem_d_wr_w);
    assign w_rd_data = (mem_d_rd_w & ~w_err) ? r_mem[w_idx] : '0;
    assign w_bd_ok   = bd_wr_i & (bd_addr_i < DEPTH_WORDS);
    assign w_bd_idx  = bd_addr_i[AW-1:0];

`ifdef TB_DMEM_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // RAM has no reset so preloaded contents survive a mid-run reset; a core
    // write to the same word suppresses the backdoor write entirely.
    always_ff @(posedge clk) begin
        if (w_bd_ok && !(w_core_wr && (w_idx == w_bd_idx))) begin
            r_mem[w_bd_idx] <= bd_data_i;
        end
        if (w_core_wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (mem_d_wr_w[b]) begin
                    r_mem[w_idx][8*b +: 8] <= mem_d_data_wr_w[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_take) begin
            r_tag[r_wr_ptr]  <= mem_d_req_tag_w;
            r_data[r_wr_ptr] <= w_rd_data;
            r_err[r_wr_ptr]  <= w_err;
        end
    end

    // Every slot counts down independently; entries are pushed in order with
    // equal countdowns, so the head is always the first to reach zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                r_cd[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ack      <= 1'b0;
            r_ack_err  <= 1'b0;
            r_ack_tag  <= '0;
            r_ack_data <= '0;
        end else begin
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                if (r_cd[i] != 4'd0) begin
                    r_cd[i] <= r_cd[i] - 4'd1;
                end
            end
            if (w_take) begin
                r_cd[r_wr_ptr] <= CD_INIT;
                r_wr_ptr       <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_ack_err  <= r_err[r_rd_ptr];
                r_ack_tag  <= r_tag[r_rd_ptr];
                r_ack_data <= r_data[r_rd_ptr];
            end
            r_count <= r_count + CW'(w_take) - CW'(w_pop);
            r_ack   <= w_pop;
        end
    end

    assign mem_d_ack_w      = r_ack;
    assign mem_d_error_w    = r_ack_err;
    assign mem_d_resp_tag_w = r_ack_tag;
    assign mem_d_data_rd_w  = r_ack_data;

endmodule

// File: tb/tb_tb_dmem_responder.sv
// Scoreboard bench for tb_dmem_responder: instance A uses defaults (LATENCY=2),
// instance B uses LATENCY=8 to exercise a full response FIFO and mid-run reset.
module tb_tb_dmem_responder;

    typedef struct {
        logic [10:0] tag;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic clk;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t qa[$];
    exp_t qb[$];

    logic        a_rst_n, a_rd, a_inv, a_wb, a_fl, a_bd_wr, a_cache;
    logic [3:0]  a_wr;
    logic [31:0] a_addr, a_wdata, a_bd_addr, a_bd_data;
    logic [10:0] a_tag;
    logic        a_accept, a_ack, a_err;
    logic [10:0] a_rtag;
    logic [31:0] a_rdata;

    logic        b_rst_n, b_rd, b_inv, b_wb, b_fl, b_bd_wr, b_cache;
    logic [3:0]  b_wr;
    logic [31:0] b_addr, b_wdata, b_bd_addr, b_bd_data;
    logic [10:0] b_tag;
    logic        b_accept, b_ack, b_err;
    logic [10:0] b_rtag;
    logic [31:0] b_rdata;

    tb_dmem_responder u_dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .mem_d_addr_w(a_addr), .mem_d_data_wr_w(a_wdata), .mem_d_rd_w(a_rd),
        .mem_d_wr_w(a_wr), .mem_d_cacheable_w(a_cache), .mem_d_req_tag_w(a_tag),
        .mem_d_invalidate_w(a_inv), .mem_d_writeback_w(a_wb), .mem_d_flush_w(a_fl),
        .bd_wr_i(a_bd_wr), .bd_addr_i(a_bd_addr), .bd_data_i(a_bd_data),
        .mem_d_accept_w(a_accept), .mem_d_ack_w(a_ack), .mem_d_error_w(a_err),
        .mem_d_resp_tag_w(a_rtag), .mem_d_data_rd_w(a_rdata)
    );

    tb_dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(8), .OUTSTANDING(4)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .mem_d_addr_w(b_addr), .mem_d_data_wr_w(b_wdata), .mem_d_rd_w(b_rd),
        .mem_d_wr_w(b_wr), .mem_d_cacheable_w(b_cache), .mem_d_req_tag_w(b_tag),
        .mem_d_invalidate_w(b_inv), .mem_d_writeback_w(b_wb), .mem_d_flush_w(b_fl),
        .bd_wr_i(b_bd_wr), .bd_addr_i(b_bd_addr), .bd_data_i(b_bd_data),
        .mem_d_accept_w(b_accept), .mem_d_ack_w(b_ack), .mem_d_error_w(b_err),
        .mem_d_resp_tag_w(b_rtag), .mem_d_data_rd_w(b_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: actual=event required=none (cycle %0d)", name, cyc);
    endtask

    // Monitors: pop one expectation per ack; an overdue head is a missing ack.
    always @(negedge clk) begin
        exp_t e;
        if (a_ack === 1'b1) begin
            if (qa.size() == 0) begin
                flag("a_unexpected_ack");
            end else begin
                e = qa.pop_front();
                check("a_tag", 32'(a_rtag), 32'(e.tag));
                check("a_data", a_rdata, e.data);
                check("a_err", 32'(a_err), 32'(e.err));
                check("a_ack_cycle", cyc, e.due);
            end
        end else if (qa.size() != 0 && cyc > qa[0].due) begin
            flag("a_missing_ack");
            void'(qa.pop_front());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_ack === 1'b1) begin
            if (qb.size() == 0) begin
                flag("b_unexpected_ack");
            end else begin
                e = qb.pop_front();
                check("b_tag", 32'(b_rtag), 32'(e.tag));
                check("b_data", b_rdata, e.data);
                check("b_err", 32'(b_err), 32'(e.err));
                check("b_ack_cycle", cyc, e.due);
            end
        end else if (qb.size() != 0 && cyc > qb[0].due) begin
            flag("b_missing_ack");
            void'(qb.pop_front());
        end
    end

    task automatic drive(input int d, input logic rd, input logic [3:0] wr, input logic fl,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [10:0] tag);
        if (d == 0) begin
            a_rd = rd; a_wr = wr; a_fl = fl; a_addr = addr; a_wdata = wdata; a_tag = tag;
        end else begin
            b_rd = rd; b_wr = wr; b_fl = fl; b_addr = addr; b_wdata = wdata; b_tag = tag;
        end
    endtask

    // Called just after a negedge; holds the request until accepted.
    task automatic req(input int d, input logic rd, input logic [3:0] wr, input logic fl,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [10:0] tag,
                       input logic [31:0] exp_data, input logic exp_err, output int waits);
        exp_t e;
        drive(d, rd, wr, fl, addr, wdata, tag);
        waits = 0;
        while (((d == 0) ? a_accept : b_accept) !== 1'b1 && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 100) begin
            flag("accept_timeout");
        end else begin
            e.tag  = tag;
            e.data = exp_data;
            e.err  = exp_err;
            e.due  = cyc + 1 + ((d == 0) ? 2 : 8);
            if (d == 0) qa.push_back(e);
            else        qb.push_back(e);
        end
        @(negedge clk);
        drive(d, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 11'h0);
    endtask

    task automatic bd(input int d, input logic [31:0] widx, input logic [31:0] data);
        if (d == 0) begin a_bd_wr = 1'b1; a_bd_addr = widx; a_bd_data = data; end
        else        begin b_bd_wr = 1'b1; b_bd_addr = widx; b_bd_data = data; end
        @(negedge clk);
        a_bd_wr = 1'b0;
        b_bd_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        cyc = 0; n_cmp = 0; n_bad = 0;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_cache = 1'b1; b_cache = 1'b0;
        a_inv = 1'b0; a_wb = 1'b0; b_inv = 1'b0; b_wb = 1'b0;
        a_bd_wr = 1'b0; a_bd_addr = '0; a_bd_data = '0;
        b_bd_wr = 1'b0; b_bd_addr = '0; b_bd_data = '0;
        drive(0, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 11'h0);
        drive(1, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 11'h0);

        repeat (3) @(negedge clk);
        check("rst_a_accept", 32'(a_accept), 32'h0);
        check("rst_a_ack", 32'(a_ack), 32'h0);
        check("rst_a_err", 32'(a_err), 32'h0);
        check("rst_a_tag", 32'(a_rtag), 32'h0);
        check("rst_a_data", a_rdata, 32'h0);
        check("rst_b_accept", 32'(b_accept), 32'h0);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_a_accept", 32'(a_accept), 32'h1);
        check("post_rst_b_accept", 32'(b_accept), 32'h1);

        bd(0, 32'd5, 32'hDEADBEEF);
        req(0, 1'b1, 4'b0000, 1'b0, 32'h14, 32'h0, 11'h012, 32'hDEADBEEF, 1'b0, w);

        bd(0, 32'd8, 32'hFFFFFFFF);
        req(0, 1'b0, 4'b0011, 1'b0, 32'h20, 32'h1234ABCD, 11'h020, 32'h0, 1'b0, w);
        req(0, 1'b1, 4'b0000, 1'b0, 32'h20, 32'h0, 11'h021, 32'hFFFFABCD, 1'b0, w);

        req(0, 1'b1, 4'b0000, 1'b0, 32'h0000_4000, 32'h0, 11'h030, 32'h0, 1'b1, w);
        req(0, 1'b0, 4'b1111, 1'b0, 32'h24, 32'h11223344, 11'h031, 32'h0, 1'b0, w);
        req(0, 1'b1, 4'b0000, 1'b0, 32'h24, 32'h0, 11'h032, 32'h11223344, 1'b0, w);
        req(0, 1'b1, 4'b1111, 1'b0, 32'h24, 32'h99999999, 11'h033, 32'h0, 1'b1, w);
        req(0, 1'b1, 4'b0000, 1'b0, 32'h24, 32'h0, 11'h034, 32'h11223344, 1'b0, w);
        req(0, 1'b0, 4'b0000, 1'b1, 32'h24, 32'h0, 11'h035, 32'h0, 1'b0, w);

        bd(0, 32'd0, 32'h00000000);
        bd(0, 32'd4096, 32'h55555555);
        bd(0, 32'd4095, 32'h0FF1CE00);
        req(0, 1'b1, 4'b0000, 1'b0, 32'h0, 32'h0, 11'h036, 32'h00000000, 1'b0, w);
        req(0, 1'b1, 4'b0000, 1'b0, 32'h3FFC, 32'h0, 11'h037, 32'h0FF1CE00, 1'b0, w);

        for (int i = 0; i < 6; i++) bd(0, 32'(16 + i), 32'hA0000000 + 32'(i));
        for (int i = 0; i < 6; i++) begin
            req(0, 1'b1, 4'b0000, 1'b0, 32'((16 + i) * 4), 32'h0, 11'h040 + 11'(i),
                32'hA0000000 + 32'(i), 1'b0, w);
            check("a_b2b_accept_waits", 32'(w), 32'h0);
        end

        for (int i = 0; i < 5; i++) bd(1, 32'(40 + i), 32'hB0000000 + 32'(i));
        for (int i = 0; i < 5; i++) begin
            req(1, 1'b1, 4'b0000, 1'b0, 32'((40 + i) * 4), 32'h0, 11'h050 + 11'(i),
                32'hB0000000 + 32'(i), 1'b0, w);
            check("b_full_accept_waits", 32'(w), (i == 4) ? 32'd5 : 32'd0);
            if (i == 3) check("b_full_accept", 32'(b_accept), 32'h0);
        end

        bd(1, 32'd60, 32'hCAFEF00D);
        repeat (20) @(negedge clk);
        req(1, 1'b0, 4'b1111, 1'b0, 32'(61 * 4), 32'h0BADF00D, 11'h060, 32'h0, 1'b0, w);
        req(1, 1'b1, 4'b0000, 1'b0, 32'(60 * 4), 32'h0, 11'h061, 32'hCAFEF00D, 1'b0, w);
        req(1, 1'b1, 4'b0000, 1'b0, 32'(61 * 4), 32'h0, 11'h062, 32'h0BADF00D, 1'b0, w);
        b_rst_n = 1'b0;
        qb.delete();
        repeat (3) begin
            @(negedge clk);
            check("b_rst_accept", 32'(b_accept), 32'h0);
            check("b_rst_ack", 32'(b_ack), 32'h0);
        end
        check("b_rst_tag", 32'(b_rtag), 32'h0);
        check("b_rst_data", b_rdata, 32'h0);
        b_rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("b_post_rst_accept", 32'(b_accept), 32'h1);
        req(1, 1'b1, 4'b0000, 1'b0, 32'(60 * 4), 32'h0, 11'h070, 32'hCAFEF00D, 1'b0, w);
        req(1, 1'b1, 4'b0000, 1'b0, 32'(61 * 4), 32'h0, 11'h071, 32'h0BADF00D, 1'b0, w);

        repeat (20) @(negedge clk);
        check("a_queue_drained", 32'(qa.size()), 32'h0);
        check("b_queue_drained", 32'(qb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tb_dmem_responder.md
# tb_dmem_responder

Data-memory responder for the core testbench. It sits directly downstream of the core's data-memory port and answers every request the core issues on `mem_d_*`. It holds a word-addressed RAM, accepts reads, writes and cache-maintenance requests, and returns an in-order acknowledge with the request tag after a fixed latency. It drives the `mem_d_accept_w`, `mem_d_ack_w`, `mem_d_error_w`, `mem_d_resp_tag_w` and `mem_d_data_rd_w` signals of the bench interface.

## Interface
- `DEPTH_WORDS`, 4096: RAM size in 32-bit words; valid word index range is 0..DEPTH_WORDS-1.
- `LATENCY`, 2: cycles from acceptance to ack; legal range 1..15.
- `OUTSTANDING`, 4: response FIFO depth; power of two, at least 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_d_addr_w`  in  32  byte address; word index is addr[31:2].
- `mem_d_data_wr_w`  in  32  write data.
- `mem_d_rd_w`  in  1  read request.
- `mem_d_wr_w`  in  4  byte write strobes.
- `mem_d_cacheable_w`  in  1  ignored; no effect on behaviour.
- `mem_d_req_tag_w`  in  11  request tag.
- `mem_d_invalidate_w`, `mem_d_writeback_w`, `mem_d_flush_w`  in  1 each  maintenance requests.
- `bd_wr_i`  in  1  backdoor preload write strobe.
- `bd_addr_i`  in  32  backdoor word index.
- `bd_data_i`  in  32  backdoor word data.
- `mem_d_accept_w`  out  1  request accepted this cycle.
- `mem_d_ack_w`  out  1  one-cycle response pulse.
- `mem_d_error_w`  out  1  response is an error; qualified by ack.
- `mem_d_resp_tag_w`  out  11  tag of the acknowledged request.
- `mem_d_data_rd_w`  out  32  read data; qualified by ack.

## Operation
- Request valid: `rd | (|wr) | flush | invalidate | writeback`.
- Handshake: a request is taken when it is valid and `mem_d_accept_w`=1.
- `mem_d_accept_w` = (FIFO count < OUTSTANDING). It is combinational from the registered count.
  - A pop in the same cycle does not raise accept.
  - Accept may be 1 while no request is valid.
- Error at take time: error=1 when the word index is ≥ DEPTH_WORDS, or when rd and wr strobes are both set. An errored request does not write RAM and returns data 0.
- Write: applied at take, per byte strobe. A later read always sees it, including a back-to-back read.
- Read: the RAM word is captured at take and stored in the FIFO entry.
- Maintenance only (no rd, no wr): acked with data 0, error 0, no RAM effect.
- FIFO entry: {tag, data, error, countdown}. At push, countdown = LATENCY-1. Countdowns of non-zero entries decrement every cycle.
- Pop: the head entry pops when its countdown is 0. The pop registers ack=1 with the head's tag/data/error on the next edge.
- Order: responses are strictly in acceptance order; at most one ack per cycle.
- Backdoor: `bd_wr_i` writes a full word at `bd_addr_i` when the index is in range and is ignored otherwise. It is meant for preload. If it coincides with a core write to the same word, the core write wins.

## Timing
- Request taken at edge N → `mem_d_ack_w`=1 during cycle N+LATENCY, for exactly one cycle.
- Throughput: one request per cycle sustained when OUTSTANDING ≥ LATENCY+1.
- Reset values: `mem_d_accept_w`=1 once rst_n is deasserted. While rst_n is low, `mem_d_accept_w`=0, `mem_d_ack_w`=0, `mem_d_error_w`=0, `mem_d_resp_tag_w`=0, `mem_d_data_rd_w`=0.
- Reset mid-operation: FIFO is emptied, pending acks are dropped, RAM contents are retained. The LFSR is reseeded to 16'hACE1.
- Full with simultaneous pop: accept stays 0 that cycle and returns to 1 the following cycle.
- Ack data/tag/error hold their last values when ack=0.

## Configuration
- `TB_DMEM_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances every cycle.
  - `mem_d_accept_w` is additionally forced to 0 whenever LFSR[1:0]==2'b00.
  - Latency is unchanged for taken requests.
- Not defined: accept depends on FIFO occupancy only; no LFSR is present.

## Test plan
- Backdoor-write word 5 = 32'hDEADBEEF. Read addr 32'h14, tag 11'h012 at cycle N → ack at N+2, data 32'hDEADBEEF, tag 11'h012, error 0.
- Write addr 32'h20, strobes 4'b0011, data 32'h1234ABCD over existing 32'hFFFFFFFF; read the same word on the next cycle → data 32'hFFFFABCD.
- Read addr 32'h0000_4000 with DEPTH_WORDS=4096 → ack with error=1, data 0. The following in-range write is unaffected.
- Issue 6 back-to-back reads with LATENCY=2 and OUTSTANDING=4 → six acks on consecutive cycles, tags in issue order, accept never drops.
- Set LATENCY=8 and OUTSTANDING=4, issue 5 reads → accept drops to 0 after the 4th take until the first ack pops. Acks arrive in order.
- Assert rst_n=0 with 3 requests pending → no acks follow, accept=0 during reset. A read issued after release returns the pre-reset RAM data.
